// File: rtl/k051962_pkg.sv
// Shared types and helpers for the k051962 tile-ROM slot arbiter.
package k051962_pkg;
  localparam int SLOT_W    = 3;
  localparam int NSLOT     = 8;
  localparam int MAX_LAYER = 3;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} cpu_st_t;

  // One-hot layer owning the pair that contains 'slot'; all-zero means CPU-eligible.
  function automatic logic [MAX_LAYER-1:0] pair_owner(
    input logic [SLOT_W-1:0]    slot,
    input logic [MAX_LAYER-1:0] lyr_en,
    input int                   nlayer
  );
    logic [1:0] p;
    pair_owner = '0;
    p = slot[SLOT_W-1:1];
    if ((int'(p) < nlayer) && lyr_en[p]) pair_owner[p] = 1'b1;
  endfunction
endpackage

// File: rtl/k051962_slot_ctr.sv
// 3-bit character slot counter: advances on pixel enable, load-to-zero wins over increment.
module k051962_slot_ctr
  import k051962_pkg::*;
(
  input  logic              i_ck,
  input  logic              i_cl,
  input  logic              i_en,
  input  logic              i_ld0,
  output logic [SLOT_W-1:0] o_slot,
  output logic [SLOT_W-1:0] o_slot_nxt
);
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_inc;

  always_comb begin
    w_inc      = (r_slot == SLOT_W'(NSLOT - 1)) ? '0 : r_slot + SLOT_W'(1);
    o_slot_nxt = i_ld0 ? '0 : w_inc;
  end

  always_ff @(posedge i_ck) begin
    if (i_cl)      r_slot <= '0;
    else if (i_en) r_slot <= o_slot_nxt;
  end

  assign o_slot = r_slot;
endmodule

// File: rtl/k051962_rom_slot_arbiter.sv
// Tile-ROM bus slot scheduler: layer pairs get shift-register fetches, leftover pairs go
// to a 4-phase CPU request/ack port.
module k051962_rom_slot_arbiter
  import k051962_pkg::*;
#(
  parameter int NLAYER       = 3,
  parameter int CPU_WAIT_MAX = 15
) (
  input  logic              i_ck,
  input  logic              i_cl,
  input  logic              i_pxce,
  input  logic              i_hld,
  input  logic [NLAYER-1:0] i_lyr_en,
  input  logic              i_cpu_req,
  output logic              o_cpu_ack,
  output logic              o_cpu_wait,
  output logic [NLAYER-1:0] o_gnt,
  output logic              o_gnt_cpu,
  output logic              o_rom_oe,
  output logic [NLAYER-1:0] o_sr_ld,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_err_to
);
  cpu_st_t r_st, w_st_nxt;

  logic                 r_hld_arm;
  logic [7:0]           r_wcnt;
  logic [NLAYER-1:0]    r_gnt, r_sr_ld;
  logic                 r_gnt_cpu, r_cpu_wait, r_cpu_ack, r_rom_oe, r_err_to;

  logic [SLOT_W-1:0]    w_slot, w_slot_nxt;
  logic [MAX_LAYER-1:0] w_en_pad, w_own_full;
  logic [NLAYER-1:0]    w_own, w_gnt_n, w_sr_ld_n;
  logic                 w_enter_even, w_leave_odd, w_acc_cont, w_wait_px;
  logic                 w_gnt_cpu_n, w_cpu_wait_n, w_cpu_ack_n, w_rom_oe_n;
  logic [7:0]           w_wcnt_inc;

  k051962_slot_ctr u_slot_ctr (
    .i_ck       (i_ck),
    .i_cl       (i_cl),
    .i_en       (i_pxce),
    .i_ld0      (i_hld | r_hld_arm),
    .o_slot     (w_slot),
    .o_slot_nxt (w_slot_nxt)
  );

  always_comb begin
    w_en_pad               = '0;
    w_en_pad[NLAYER-1:0]   = i_lyr_en;
    w_own_full             = pair_owner(w_slot_nxt, w_en_pad, NLAYER);
    w_own                  = w_own_full[NLAYER-1:0];
    w_enter_even           = i_pxce & ~w_slot_nxt[0];
    w_leave_odd            = i_pxce & w_slot[0];
    // An even-to-even step while in ACCESS is an HLD restart: the CPU keeps the new pair.
    w_acc_cont             = (r_st == ACCESS) & i_pxce & ~w_slot[0];
    w_wait_px              = (r_st == WAIT) & i_pxce;
    w_wcnt_inc             = r_wcnt + 8'd1;
  end

  // FSM: state register
  always_ff @(posedge i_ck) begin
    if (i_cl) r_st <= IDLE;
    else      r_st <= w_st_nxt;
  end

  // FSM: next state
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      IDLE:    if (i_cpu_req) w_st_nxt = WAIT;
      WAIT:    if (!i_cpu_req)                  w_st_nxt = IDLE;
               else if (w_enter_even && !(|w_own)) w_st_nxt = ACCESS;
      ACCESS:  if (w_leave_odd) w_st_nxt = DONE;
      DONE:    if (!i_cpu_req) w_st_nxt = IDLE;
      default: w_st_nxt = IDLE;
    endcase
  end

  // FSM: outputs, decoded from the next state so they register in step with it
  always_comb begin
    w_gnt_cpu_n  = (w_st_nxt == ACCESS);
    w_cpu_wait_n = (w_st_nxt == WAIT);
    w_cpu_ack_n  = (w_st_nxt == DONE);
    w_gnt_n      = r_gnt;
    if (w_enter_even) w_gnt_n = w_acc_cont ? '0 : w_own;
    w_sr_ld_n    = w_leave_odd ? r_gnt : '0;
    w_rom_oe_n   = (|w_gnt_n) | w_gnt_cpu_n;
  end

  always_ff @(posedge i_ck) begin
    if (i_cl) begin
      r_hld_arm  <= 1'b0;
      r_wcnt     <= '0;
      r_err_to   <= 1'b0;
      r_gnt      <= '0;
      r_sr_ld    <= '0;
      r_gnt_cpu  <= 1'b0;
      r_cpu_wait <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_rom_oe   <= 1'b0;
    end else begin
      if (i_pxce)     r_hld_arm <= 1'b0;
      else if (i_hld) r_hld_arm <= 1'b1;

      if ((w_st_nxt == IDLE) && (r_st != IDLE))
        r_wcnt <= '0;
      else if (w_wait_px && (r_wcnt != 8'(CPU_WAIT_MAX)))
        r_wcnt <= w_wcnt_inc;

      if (w_wait_px && (w_wcnt_inc == 8'(CPU_WAIT_MAX))) r_err_to <= 1'b1;

      r_gnt      <= w_gnt_n;
      r_sr_ld    <= w_sr_ld_n;
      r_gnt_cpu  <= w_gnt_cpu_n;
      r_cpu_wait <= w_cpu_wait_n;
      r_cpu_ack  <= w_cpu_ack_n;
      r_rom_oe   <= w_rom_oe_n;
    end
  end

  assign o_slot     = w_slot;
  assign o_gnt      = r_gnt;
  assign o_sr_ld    = r_sr_ld;
  assign o_gnt_cpu  = r_gnt_cpu;
  assign o_cpu_wait = r_cpu_wait;
  assign o_cpu_ack  = r_cpu_ack;
  assign o_rom_oe   = r_rom_oe;
  assign o_err_to   = r_err_to;
endmodule

// File: tb/tb_k051962_rom_slot_arbiter.sv
// Directed scoreboard bench for the slot arbiter; expectations are queued per cycle.
module tb_k051962_rom_slot_arbiter;
  localparam int NL = 3;

  logic          ck = 1'b0, cl = 1'b1, pxce = 1'b0, hld = 1'b0, req = 1'b0;
  logic [NL-1:0] lyr_en = '1;
  logic          cpu_ack, cpu_wait, gnt_cpu, rom_oe, err_to;
  logic [NL-1:0] gnt, sr_ld;
  logic [2:0]    slot;

  int cyc = 0, n_chk = 0, n_fail = 0;

  typedef enum int {S_SLOT, S_GNT, S_GCPU, S_WAIT, S_ACK, S_SRLD, S_OE, S_ERR} sig_t;
  typedef struct { int cyc; string nm; sig_t sig; int val; } exp_t;
  exp_t sb[$];
  exp_t m_e;

  logic [2:0] gtbl [8];
  logic [2:0] stbl [8];

  k051962_rom_slot_arbiter #(.NLAYER(NL), .CPU_WAIT_MAX(4)) dut (
    .i_ck(ck), .i_cl(cl), .i_pxce(pxce), .i_hld(hld), .i_lyr_en(lyr_en),
    .i_cpu_req(req), .o_cpu_ack(cpu_ack), .o_cpu_wait(cpu_wait), .o_gnt(gnt),
    .o_gnt_cpu(gnt_cpu), .o_rom_oe(rom_oe), .o_sr_ld(sr_ld), .o_slot(slot),
    .o_err_to(err_to)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  function automatic int act(sig_t s);
    case (s)
      S_SLOT:  return int'(slot);
      S_GNT:   return int'(gnt);
      S_GCPU:  return int'(gnt_cpu);
      S_WAIT:  return int'(cpu_wait);
      S_ACK:   return int'(cpu_ack);
      S_SRLD:  return int'(sr_ld);
      S_OE:    return int'(rom_oe);
      S_ERR:   return int'(err_to);
      default: return -1;
    endcase
  endfunction

  // Monitor: compares every queued expectation on the cycle it targets.
  always @(negedge ck) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      n_chk++;
      if (m_e.cyc != cyc || act(m_e.sig) != m_e.val) begin
        n_fail++;
        $display("FAIL %s: actual %0d expected %0d (cycle %0d, due %0d)",
                 m_e.nm, act(m_e.sig), m_e.val, cyc, m_e.cyc);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge ck); #1; end
  endtask

  task automatic ex(string nm, sig_t s, int v, int ofs = 0);
    exp_t e;
    e.cyc = cyc + ofs; e.nm = nm; e.sig = s; e.val = v;
    sb.push_back(e);
  endtask

  task automatic pix(logic h = 1'b0);
    pxce = 1'b1; hld = h; tick(); pxce = 1'b0; hld = 1'b0;
  endtask

  task automatic rst();
    cl = 1'b1; tick(); cl = 1'b0;
  endtask

  task automatic adv(int n);
    repeat (n) begin pix(); tick(3); end
  endtask

  // Reset, then run a full period so pair 0 is latched on entry to slot 0.
  task automatic goto0();
    rst(); adv(8);
  endtask

  initial begin
    gtbl = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000, 3'b000};
    stbl = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};

    // 1: reset state and layer-only schedule
    lyr_en = 3'b111; rst();
    ex("rst_slot", S_SLOT, 0); ex("rst_gnt", S_GNT, 0); ex("rst_oe", S_OE, 0);
    ex("rst_gcpu", S_GCPU, 0); ex("rst_ack", S_ACK, 0); ex("rst_err", S_ERR, 0);
    adv(8);
    ex("t1_slot0", S_SLOT, 0); ex("t1_gnt0", S_GNT, 1);
    tick(3);
    for (int i = 1; i <= 8; i++) begin
      pix();
      ex("t1_slot", S_SLOT, i % 8);
      ex("t1_gnt", S_GNT, int'(gtbl[i % 8]));
      ex("t1_oe", S_OE, (gtbl[i % 8] != 3'b000) ? 1 : 0);
      ex("t1_srld", S_SRLD, int'(stbl[i % 8]));
      ex("t1_srld_pulse", S_SRLD, 0, 1);
      tick(3);
    end

    // 2: CPU request at slot 2, granted over slots 6-7
    goto0(); adv(1); pix(); ex("t2_slot2", S_SLOT, 2);
    req = 1'b1; tick(); ex("t2_wait_on", S_WAIT, 1); tick(2);
    pix(); ex("t2_s3_wait", S_WAIT, 1); ex("t2_s3_gcpu", S_GCPU, 0); tick(3);
    adv(1);
    pix(); ex("t2_s5_wait", S_WAIT, 1); ex("t2_s5_err", S_ERR, 0); tick(3);
    pix(); ex("t2_s6_gcpu", S_GCPU, 1); ex("t2_s6_wait", S_WAIT, 0);
    ex("t2_s6_gnt", S_GNT, 0); ex("t2_s6_oe", S_OE, 1); ex("t2_s6_err", S_ERR, 1); tick(3);
    pix(); ex("t2_s7_gcpu", S_GCPU, 1); ex("t2_s7_ack", S_ACK, 0); tick(3);
    pix(); ex("t2_ack", S_ACK, 1); ex("t2_s0_gcpu", S_GCPU, 0); ex("t2_s0_gnt", S_GNT, 1);
    tick(3); ex("t2_ack_hold", S_ACK, 1);
    req = 1'b0; tick(); ex("t2_ack_drop", S_ACK, 0); tick(2);

    // 3: layer 1 disabled, pair 1 goes to the CPU; mid-pair enable change deferred
    lyr_en = 3'b101; goto0();
    req = 1'b1; tick(); ex("t3_wait_on", S_WAIT, 1); tick(2);
    pix(); ex("t3_s1_wait", S_WAIT, 1); tick(3);
    pix(); ex("t3_s2_gcpu", S_GCPU, 1); ex("t3_s2_gnt", S_GNT, 0); tick(3);
    pix(); ex("t3_s3_gcpu", S_GCPU, 1);
    lyr_en = 3'b111; tick(); ex("t3_s3_gnt", S_GNT, 0); tick(2);
    pix(); ex("t3_ack", S_ACK, 1); ex("t3_s4_gnt", S_GNT, 4); ex("t3_s4_srld", S_SRLD, 0);
    req = 1'b0; tick(); ex("t3_ack_drop", S_ACK, 0); tick(2);
    adv(5);
    pix(); ex("t3_en_next", S_GNT, 2); tick(3);

    // 4: HLD realign, armed and immediate
    lyr_en = 3'b111; goto0(); adv(5);
    hld = 1'b1; tick(); hld = 1'b0; ex("t4_hld_hold", S_SLOT, 5); tick(2);
    pix(); ex("t4_realign", S_SLOT, 0); ex("t4_s0_gnt", S_GNT, 1); ex("t4_sr_s5", S_SRLD, 4); tick(3);
    adv(3);
    pix(1'b1); ex("t4_hld_px", S_SLOT, 0); ex("t4_hp_gnt", S_GNT, 1); ex("t4_sr_s3", S_SRLD, 2); tick(3);
    pix(); ex("t4_after", S_SLOT, 1); tick(3);

    // 5: starvation flag with CPU_WAIT_MAX=4
    goto0(); adv(7);
    req = 1'b1; tick(); ex("t5_wait_on", S_WAIT, 1); ex("t5_err0", S_ERR, 0); tick(2);
    pix(); ex("t5_err_1", S_ERR, 0); tick(3);
    adv(1);
    pix(); ex("t5_err_3", S_ERR, 0); tick(3);
    pix(); ex("t5_err_4", S_ERR, 1); ex("t5_s3_gcpu", S_GCPU, 0); tick(3);
    adv(1);
    pix(); ex("t5_s5_wait", S_WAIT, 1); tick(3);
    pix(); ex("t5_s6_gcpu", S_GCPU, 1); ex("t5_s6_err", S_ERR, 1); tick(3);
    adv(1);
    pix(); ex("t5_ack", S_ACK, 1);
    req = 1'b0; tick(); ex("t5_ack_drop", S_ACK, 0); ex("t5_err_sticky", S_ERR, 1); tick(2);
    rst(); ex("t5_err_cl", S_ERR, 0);

    // 6: reset during ACCESS aborts, held request is re-granted at the next free pair
    goto0();
    req = 1'b1; tick(3);
    adv(5);
    pix(); ex("t6_s6_gcpu", S_GCPU, 1); tick();
    rst();
    ex("t6_slot", S_SLOT, 0); ex("t6_gcpu", S_GCPU, 0); ex("t6_ack", S_ACK, 0);
    ex("t6_wait", S_WAIT, 0); ex("t6_gnt", S_GNT, 0); ex("t6_oe", S_OE, 0); ex("t6_err", S_ERR, 0);
    tick(); ex("t6_rewait", S_WAIT, 1); tick(2);
    adv(4);
    pix(); ex("t6_s5_wait", S_WAIT, 1); ex("t6_s5_ack", S_ACK, 0); tick(3);
    pix(); ex("t6_regrant", S_GCPU, 1); tick(3);

    tick(2);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
